// File: rtl/axi_ram_read_if.sv
// AXI3 read address and read data channels between the interconnect (master) and a RAM read slave.
interface axi_ram_read_if;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [3:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  modport master (
    output arid, araddr, arlen, arsize, arburst, arvalid, rready,
    input  arready, rid, rdata, rresp, rlast, rvalid
  );
  modport slave (
    input  arid, araddr, arlen, arsize, arburst, arvalid, rready,
    output arready, rid, rdata, rresp, rlast, rvalid
  );
endinterface

// File: rtl/axi_ram_read_slave.sv
// AXI3 read slave serving one burst at a time from a synchronous-read RAM,
// with a 2-entry R buffer plus a bypass of the returning RAM word.
module axi_ram_read_slave #(
  parameter int DEPTH_LOG2 = 12
) (
  input  logic                  clk,
  input  logic                  reset,
  axi_ram_read_if.slave         axi,
  output logic                  ram_en,
  output logic [DEPTH_LOG2-1:0] ram_addr,
  input  logic [31:0]           ram_rdata
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;
  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;
  localparam logic [1:0] DECERR = 2'b11;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } beat_t;

  logic [0:0]            state_q, state_d;
  logic                  arready_q, arready_d;
  logic [3:0]            id_q, id_d;
  logic [3:0]            len_q, len_d;
  logic [1:0]            burst_q, burst_d;
  logic [1:0]            err_q, err_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [4:0]            iss_q, iss_d;
  logic                  infl_q, infl_d;
  logic                  infl_last_q, infl_last_d;
  beat_t [1:0]           fifo_q, fifo_d;
  logic [1:0]            cnt_q, cnt_d;

  logic                  accept, issue, rvalid, hs, pop, push;
  logic [1:0]            ar_err, occ;
  logic [DEPTH_LOG2-1:0] idx_inc, wmask, idx_next;
  beat_t                 infl_beat, head;

  always_comb begin
    accept = axi.arvalid && arready_q;
    if (axi.araddr[31:DEPTH_LOG2+2] != '0)
      ar_err = DECERR;
    else if (axi.arsize != 3'b010 || axi.araddr[1:0] != 2'b00 || axi.arburst == 2'b11)
      ar_err = SLVERR;
    else if (axi.arburst == 2'b10 && !(axi.arlen inside {4'd1, 4'd3, 4'd7, 4'd15}))
      ar_err = SLVERR;
    else
      ar_err = OKAY;
  end

  // Wrap lengths are 2^k-1, so len itself is the mask of the wrapping bits.
  always_comb begin
    idx_inc = idx_q + DEPTH_LOG2'(1);
    wmask   = DEPTH_LOG2'(len_q);
    case (burst_q)
      2'b00:   idx_next = idx_q;
      2'b10:   idx_next = (idx_q & ~wmask) | (idx_inc & wmask);
      default: idx_next = idx_inc;
    endcase
  end

  // Issue only while buffered + in-flight beats stay below the FIFO depth.
  always_comb begin
    occ    = cnt_q + {1'b0, infl_q};
    issue  = (state_q == BUSY) && (iss_q <= {1'b0, len_q}) && (occ < 2'd2);
    ram_en = issue && (err_q == OKAY);
    ram_addr = idx_q;

    infl_beat.data = (err_q == OKAY) ? ram_rdata : 32'h0;
    infl_beat.resp = err_q;
    infl_beat.last = infl_last_q;

    rvalid = (cnt_q != 2'd0) || infl_q;
    if (cnt_q != 2'd0) head = fifo_q[0];
    else if (infl_q)   head = infl_beat;
    else               head = '0;
    hs   = rvalid && axi.rready;
    pop  = hs && (cnt_q != 2'd0);
    push = infl_q && !(hs && cnt_q == 2'd0);
  end

  always_comb begin
    fifo_d = fifo_q;
    cnt_d  = cnt_q;
    if (pop) begin
      fifo_d[0] = fifo_q[1];
      cnt_d     = cnt_q - 2'd1;
    end
    if (push) begin
      fifo_d[cnt_d[0]] = infl_beat;
      cnt_d            = cnt_d + 2'd1;
    end

    state_d = state_q;
    id_d    = id_q;
    len_d   = len_q;
    burst_d = burst_q;
    err_d   = err_q;
    idx_d   = idx_q;
    iss_d   = iss_q;
    if (accept) begin
      state_d = BUSY;
      id_d    = axi.arid;
      len_d   = axi.arlen;
      burst_d = axi.arburst;
      err_d   = ar_err;
      idx_d   = axi.araddr[DEPTH_LOG2+1:2];
      iss_d   = 5'd0;
    end else if (issue) begin
      idx_d = idx_next;
      iss_d = iss_q + 5'd1;
    end
    if (hs && head.last) state_d = IDLE;

    infl_d      = issue;
    infl_last_d = issue && (iss_q == {1'b0, len_q});
    arready_d   = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      arready_q   <= 1'b0;
      id_q        <= '0;
      len_q       <= '0;
      burst_q     <= '0;
      err_q       <= OKAY;
      idx_q       <= '0;
      iss_q       <= '0;
      infl_q      <= 1'b0;
      infl_last_q <= 1'b0;
      fifo_q      <= '0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      arready_q   <= arready_d;
      id_q        <= id_d;
      len_q       <= len_d;
      burst_q     <= burst_d;
      err_q       <= err_d;
      idx_q       <= idx_d;
      iss_q       <= iss_d;
      infl_q      <= infl_d;
      infl_last_q <= infl_last_d;
      fifo_q      <= fifo_d;
      cnt_q       <= cnt_d;
    end
  end

  assign axi.arready = arready_q;
  assign axi.rvalid  = rvalid;
  assign axi.rid     = id_q;
  assign axi.rdata   = head.data;
  assign axi.rresp   = head.resp;
  assign axi.rlast   = head.last;
endmodule

// File: tb/tb_axi_ram_read_slave.sv
// Bench for axi_ram_read_slave: directed and random bursts against a burst-level model.
module tb_axi_ram_read_slave;
  localparam int DL = 12;

  logic          clk;
  logic          reset;
  logic          ram_en;
  logic [DL-1:0] ram_addr;
  logic [31:0]   ram_rdata;
  logic [31:0]   mem [0:4095];
  int            checks = 0;
  int            errors = 0;

  axi_ram_read_if axi();

  axi_ram_read_slave #(.DEPTH_LOG2(DL)) dut (
    .clk(clk), .reset(reset), .axi(axi),
    .ram_en(ram_en), .ram_addr(ram_addr), .ram_rdata(ram_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ram_en) ram_rdata <= mem[ram_addr];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Expected response from the burst rules alone.
  function automatic logic [1:0] model_resp(input logic [31:0] addr, input logic [3:0] len,
                                            input logic [2:0] size, input logic [1:0] burst);
    if ((addr >> (DL + 2)) != 0) return 2'b11;
    if (size != 3'd2 || addr % 4 != 0 || burst == 2'd3) return 2'b10;
    if (burst == 2'd2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 2'b10;
    return 2'b00;
  endfunction

  function automatic int model_addr(input logic [31:0] addr, input logic [3:0] len,
                                    input logic [1:0] burst, input int i);
    int idx, n, base;
    idx = (addr / 4) % 4096;
    n   = len + 1;
    if (burst == 2'd0) return idx;
    if (burst == 2'd2) begin
      base = idx - (idx % n);
      return base + ((idx % n + i) % n);
    end
    return (idx + i) % 4096;
  endfunction

  // mode 0: rready always 1; 1: per-valid-cycle pattern (LSB first); 2: random.
  task automatic run_burst(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                           input logic [2:0] size, input logic [1:0] burst,
                           input int mode, input logic [15:0] pat);
    logic [31:0] ed [16];
    int          ea [16];
    logic [1:0]  er;
    int          n, beats, reads, cyc, vcyc, first_v, last_c, w;
    bit          done, allr, r;
    n  = len + 1;
    er = model_resp(addr, len, size, burst);
    for (int i = 0; i < n; i++) begin
      ea[i] = model_addr(addr, len, burst, i);
      ed[i] = (er == 2'b00) ? mem[ea[i]] : 32'h0;
    end
    w = 0;
    while (!axi.arready && w < 50) begin @(negedge clk); w++; end
    chk("ar_wait", {31'b0, axi.arready}, 32'd1);
    axi.arid = id; axi.araddr = addr; axi.arlen = len;
    axi.arsize = size; axi.arburst = burst; axi.arvalid = 1'b1;
    @(negedge clk);
    // arvalid stays high with junk payload while busy; the slave must ignore it
    axi.arid = ~id; axi.araddr = $urandom; axi.arlen = 4'($urandom);
    chk("arready_busy", {31'b0, axi.arready}, 32'd0);
    cyc = 1; beats = 0; reads = 0; vcyc = 0; first_v = 0; last_c = 0;
    done = 0; allr = 1;
    while (!done && cyc < 200) begin
      if (ram_en) begin
        chk("ram_en_okay_only", {30'b0, er}, 32'd0);
        chk("ram_occ", (reads - beats) < 2 ? 32'd1 : 32'd0, 32'd1);
        if (reads < n) chk("ram_addr", 32'(ram_addr), 32'(ea[reads]));
        reads++;
      end
      if (axi.rvalid) begin
        if (first_v == 0) first_v = cyc;
        chk("rid", {28'b0, axi.rid}, {28'b0, id});
        chk("rdata", axi.rdata, ed[beats]);
        chk("rresp", {30'b0, axi.rresp}, {30'b0, er});
        chk("rlast", {31'b0, axi.rlast}, (beats == n - 1) ? 32'd1 : 32'd0);
        case (mode)
          0:       r = 1'b1;
          1:       r = (vcyc < 16) ? pat[vcyc] : 1'b1;
          default: r = 1'($urandom_range(0, 1));
        endcase
        vcyc++;
        if (!r) allr = 0;
        axi.rready = r;
        if (r) begin
          beats++;
          if (beats == n) begin done = 1; last_c = cyc; axi.arvalid = 1'b0; end
        end
      end else begin
        axi.rready = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
      cyc++;
    end
    chk("burst_done", {31'b0, done}, 32'd1);
    chk("first_rvalid_cycle", 32'(first_v), 32'd2);
    if (allr) chk("last_beat_cycle", 32'(last_c), 32'(2 + len));
    chk("arready_after", {31'b0, axi.arready}, 32'd1);
    chk("rvalid_after", {31'b0, axi.rvalid}, 32'd0);
    chk("ram_reads", 32'(reads), (er == 2'b00) ? 32'(n) : 32'd0);
    axi.arvalid = 1'b0;
    axi.rready  = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_arready"}, {31'b0, axi.arready}, 32'd0);
    chk({tag, "_rvalid"},  {31'b0, axi.rvalid}, 32'd0);
    chk({tag, "_rlast"},   {31'b0, axi.rlast}, 32'd0);
    chk({tag, "_rresp"},   {30'b0, axi.rresp}, 32'd0);
    chk({tag, "_rid"},     {28'b0, axi.rid}, 32'd0);
    chk({tag, "_rdata"},   axi.rdata, 32'd0);
    chk({tag, "_ram_en"},  {31'b0, ram_en}, 32'd0);
    chk({tag, "_ram_addr"}, 32'(ram_addr), 32'd0);
  endtask

  initial begin
    logic [31:0] a;
    logic [3:0]  l;
    logic [1:0]  b;
    logic [2:0]  s;
    for (int i = 0; i < 4096; i++) mem[i] = $urandom;
    mem[5] = 32'hDEADBEEF;
    axi.arid = '0; axi.araddr = '0; axi.arlen = '0; axi.arsize = 3'd2;
    axi.arburst = 2'd1; axi.arvalid = 1'b0; axi.rready = 1'b0;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b0;
    @(negedge clk);
    chk("arready_rise", {31'b0, axi.arready}, 32'd1);

    run_burst(4'd3, 32'h14, 4'd0, 3'd2, 2'd0, 0, 16'h0);      // single read of RAM[5]
    run_burst(4'd5, 32'h100, 4'd3, 3'd2, 2'd1, 1, 16'h0059);  // INCR with stalls
    run_burst(4'd7, 32'h28, 4'd3, 3'd2, 2'd2, 0, 16'h0);      // WRAP 10,11,8,9
    run_burst(4'd1, 32'h0001_0000, 4'd2, 3'd2, 2'd1, 0, 16'h0); // DECERR
    run_burst(4'd2, 32'h40, 4'd1, 3'd1, 2'd1, 2, 16'h0);      // SLVERR size
    run_burst(4'd4, 32'h40, 4'd2, 3'd2, 2'd2, 0, 16'h0);      // SLVERR wrap len
    run_burst(4'd6, 32'h41, 4'd0, 3'd2, 2'd1, 0, 16'h0);      // SLVERR misaligned
    run_burst(4'd8, 32'h80, 4'd1, 3'd2, 2'd3, 0, 16'h0);      // SLVERR reserved burst
    run_burst(4'd9, 32'h3FF8, 4'd3, 3'd2, 2'd1, 0, 16'h0);    // INCR wraps top of RAM
    run_burst(4'hA, 32'h200, 4'd3, 3'd2, 2'd0, 2, 16'h0);     // FIXED
    run_burst(4'hB, 32'h3C0, 4'd15, 3'd2, 2'd2, 2, 16'h0);    // WRAP 16

    for (int k = 0; k < 20; k++) begin
      a = ($urandom_range(0, 9) == 0) ? $urandom : {18'b0, 12'($urandom), 2'b00};
      l = 4'($urandom);
      b = 2'($urandom_range(0, 2));
      s = ($urandom_range(0, 9) == 0) ? 3'($urandom) : 3'd2;
      run_burst(4'($urandom), a, l, s, b, 2, 16'h0);
    end

    // reset during beat 2 of an 8-beat INCR
    axi.arid = 4'hC; axi.araddr = 32'h200; axi.arlen = 4'd7;
    axi.arsize = 3'd2; axi.arburst = 2'd1; axi.arvalid = 1'b1; axi.rready = 1'b1;
    @(negedge clk);
    axi.arvalid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("mid_rst_beat2_valid", {31'b0, axi.rvalid}, 32'd1);
    chk("mid_rst_beat2_data", axi.rdata, mem[12'h81]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk_reset_vals("mid_rst");
    @(negedge clk);
    chk("mid_rst_arready", {31'b0, axi.arready}, 32'd1);
    for (int k = 0; k < 10; k++) begin
      chk("mid_rst_no_rvalid", {31'b0, axi.rvalid}, 32'd0);
      chk("mid_rst_no_ram_en", {31'b0, ram_en}, 32'd0);
      @(negedge clk);
    end
    axi.rready = 1'b0;
    run_burst(4'hD, 32'h300, 4'd2, 3'd2, 2'd1, 0, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
